// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset/exception vectors and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR       = 32'h0000_4180;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  // Word fetches require the two low address bits to be zero.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over
// req/gnt/rvalid and presents it to decode with a valid/ready handshake.
module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] npc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_adel
);

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            adel_q, adel_d;

  // State, PC and instruction latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adel_q  <= adel_d;
    end
  end

  // Next-state and register update decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    adel_d  = adel_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (pc_misaligned(pc_q)) begin
          // Address error is reported to decode without touching memory.
          instr_d = '0;
          adel_d  = 1'b1;
          state_d = HOLD;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          adel_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = npc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only
  assign pc          = pc_q;
  assign imem_req    = (state_q == REQ) && !pc_misaligned(pc_q);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_adel  = adel_q;

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for the instruction fetch unit.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_adel;

  int errors = 0;
  int checks = 0;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .npc         (npc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_adel  (instr_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc = 32'h1234_5678; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_3000); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b want 0", instr_adel); end
    checks++; if (imem_addr !== 32'h0000_3000 || instr_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_addr: addr %h instr_pc %h want 00003000", imem_addr, instr_pc); end
  endtask

  task automatic test_basic_fetch();
    rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1; npc = 32'h0000_3004;
    tick(); // IDLE -> REQ
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL basic_req: req %b addr %h want 1 00003000", imem_req, imem_addr); end
    tick(); // REQ -> WAIT
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_wait: req %b valid %b want 0 0", imem_req, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h2408_0005;
    tick(); // WAIT -> HOLD
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2408_0005 || instr_pc !== 32'h0000_3000 || instr_adel !== 1'b0) begin
      errors++; $display("FAIL basic_hold: valid %b instr %h pc %h adel %b want 1 24080005 00003000 0",
                         instr_valid, instr, instr_pc, instr_adel); end
    tick(); // accept -> REQ at npc
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_next: req %b addr %h valid %b want 1 00003004 0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_gnt_stall();
    imem_gnt = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004) begin
        errors++; $display("FAIL stall_req%0d: req %b addr %h want 1 00003004", i, imem_req, imem_addr); end
    end
    imem_gnt = 1'b1;
    tick(); // REQ -> WAIT
    imem_gnt = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL stall_wait: req %b valid %b want 0 0", imem_req, instr_valid); end
    tick(); // stays in WAIT, no second request
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL stall_one_wait: req %b valid %b want 0 0", imem_req, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h8C09_0010;
    tick(); // WAIT -> HOLD
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C09_0010) begin
      errors++; $display("FAIL stall_data: valid %b instr %h want 1 8c090010", instr_valid, instr); end
  endtask

  task automatic test_hold_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      npc = (i % 2 == 0) ? 32'hAAAA_AAA8 : 32'h5555_5554;
      imem_rvalid = (i % 2 == 0); imem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C09_0010 || pc !== 32'h0000_3004) begin
        errors++; $display("FAIL hold%0d: valid %b instr %h pc %h want 1 8c090010 00003004", i, instr_valid, instr, pc); end
    end
    imem_rvalid = 1'b0; instr_ready = 1'b1; npc = 32'h0000_4180;
    tick();
    instr_ready = 1'b0;
    checks++; if (pc !== 32'h0000_4180 || imem_req !== 1'b1 || imem_addr !== 32'h0000_4180) begin
      errors++; $display("FAIL hold_accept: pc %h req %b addr %h want 00004180 1 00004180", pc, imem_req, imem_addr); end
  endtask

  task automatic test_spurious_rvalid();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    checks++; if (imem_req !== 1'b1 || instr !== 32'h8C09_0010 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_req: req %b instr %h valid %b want 1 8c090010 0", imem_req, instr, instr_valid); end
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    tick(); // -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1234;
    tick(); // -> HOLD
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h3C01_1234 || instr_pc !== 32'h0000_4180) begin
      errors++; $display("FAIL spurious_fetch: valid %b instr %h pc %h want 1 3c011234 00004180", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_misaligned();
    instr_ready = 1'b1; npc = 32'h0000_3002; imem_gnt = 1'b1;
    tick(); // accept -> REQ at misaligned pc
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_3002) begin
      errors++; $display("FAIL adel_req: req %b valid %b pc %h want 0 0 00003002", imem_req, instr_valid, pc); end
    tick(); // REQ -> HOLD
    checks++; if (instr_valid !== 1'b1 || instr_adel !== 1'b1 || instr !== 32'h0 || instr_pc !== 32'h0000_3002 || imem_req !== 1'b0) begin
      errors++; $display("FAIL adel_hold: valid %b adel %b instr %h pc %h req %b want 1 1 0 00003002 0",
                         instr_valid, instr_adel, instr, instr_pc, imem_req); end
    instr_ready = 1'b1; npc = 32'h0000_3008;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008) begin
      errors++; $display("FAIL adel_recover: req %b addr %h want 1 00003008", imem_req, imem_addr); end
    tick(); // gnt=1 -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
    tick(); // -> HOLD
    imem_rvalid = 1'b0;
    checks++; if (instr_adel !== 1'b0 || instr !== 32'h0000_0020) begin
      errors++; $display("FAIL adel_clear: adel %b instr %h want 0 00000020", instr_adel, instr); end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1; npc = 32'hFFFF_FFFC;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: req %b addr %h want 1 fffffffc", imem_req, imem_addr); end
    tick(); // -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick(); // -> HOLD
    imem_rvalid = 1'b0; instr_ready = 1'b1; npc = 32'h0000_0000;
    tick();
    instr_ready = 1'b0;
    checks++; if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: pc %h req %b addr %h want 0 1 0", pc, imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    tick(); // gnt=1 -> WAIT
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_wait: req %b valid %b want 0 0", imem_req, instr_valid); end
    rst_n = 1'b0; imem_gnt = 1'b0;
    tick();
    checks++; if (pc !== 32'h0000_3000 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rstw_reset: pc %h instr %h valid %b req %b want 00003000 0 0 0", pc, instr, instr_valid, imem_req); end
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); // IDLE -> REQ, late response ignored
    tick();
    checks++; if (instr !== 32'h0 || imem_req !== 1'b1 || pc !== 32'h0000_3000) begin
      errors++; $display("FAIL rstw_late: instr %h req %b pc %h want 0 1 00003000", instr, imem_req, pc); end
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    tick(); // -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hABCD_0123;
    tick(); // -> HOLD
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hABCD_0123 || instr_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL rstw_fetch: valid %b instr %h pc %h want 1 abcd0123 00003000", instr_valid, instr, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_gnt_stall();
    test_hold_stall();
    test_spurious_rvalid();
    test_misaligned();
    test_wrap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the architectural PC register and fetches one instruction at a time from instruction memory over a request/grant/response handshake. It presents the fetched word to decode with a valid/ready handshake. It exports the current PC to the next-PC logic and loads that logic's `npc` result when decode accepts the instruction. It sits between the next-PC logic and decode, and is the only sequential owner of `pc`.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC value loaded on reset.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `pc` output 32: current PC register; feeds next-PC logic.
- `npc` input 32: next PC from next-PC logic; sampled only on decode accept.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: word address; equals `pc` whenever `imem_req`=1.
- `imem_gnt` input 1: memory accepted the request this cycle.
- `imem_rvalid` input 1: response data valid.
- `imem_rdata` input 32: response instruction word.
- `instr_valid` output 1: `instr`/`instr_pc`/`instr_adel` valid to decode.
- `instr_ready` input 1: decode accepts this cycle.
- `instr` output 32: fetched instruction; 0 when `instr_adel`=1.
- `instr_pc` output 32: PC of `instr`; equals `pc` while `instr_valid`=1.
- `instr_adel` output 1: fetch address error (`pc[1:0]`≠0).

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: reset state; unconditionally go to REQ next cycle.
- REQ, `pc[1:0]`≠0: `imem_req`=0; latch `instr`=0, `instr_adel`=1; go to HOLD. No memory request is issued.
- REQ, aligned: `imem_req`=1, `imem_addr`=`pc`; hold until `imem_gnt`=1, then go to WAIT.
- WAIT: when `imem_rvalid`=1, latch `imem_rdata` into `instr` and set `instr_adel`=0; go to HOLD.
- HOLD: `instr_valid`=1. On `instr_ready`=1, load `pc` from `npc` and go to REQ. Otherwise hold all outputs stable.
- `imem_rvalid` outside WAIT is ignored and does not disturb `instr`.
- `pc` changes only on the HOLD accept and on reset. `npc` is a don't-care in every other cycle.
- `npc` is loaded verbatim, with no alignment or arithmetic check here. Misalignment is detected in the following REQ.
- Outputs `imem_req`, `instr_valid`, `imem_addr` are decoded from state/registers only. No combinational path from any input to any output.

## Timing
- Reset (`rst_n`=0 at edge): state=IDLE, `pc`=`PC_RESET`, `instr`=0, `instr_adel`=0, `imem_req`=0, `instr_valid`=0. `imem_addr` and `instr_pc` follow `pc`.
- Reset mid-operation (any state, including WAIT with a response outstanding) forces the same values. A late `imem_rvalid` is dropped because the FSM is no longer in WAIT.
- Best-case aligned fetch is 4 cycles per instruction:
  - c0 IDLE→REQ, or the accept edge
  - c1 REQ with `gnt`
  - c2 WAIT with `rvalid`
  - c3 HOLD with `ready`
- Misaligned PC: REQ→HOLD in 1 cycle.
- `imem_gnt` and `imem_rvalid` may stall indefinitely. `imem_req` and `imem_addr` stay stable until `gnt`.
- `imem_rvalid` is not accepted in the same cycle as `gnt`; the earliest response is the cycle after `gnt`.
- `instr_ready` may be low for any duration. Outputs are held, and the `npc` value presented on the accept cycle is the one loaded.
- PC wrap: `npc`=32'hFFFF_FFFC followed by 32'h0000_0000 is legal. Address arithmetic is the caller's responsibility.

## Structure
- Shared package `mips_pkg`:
  - default `PC_RESET` constant 32'h0000_3000
  - exception vector 32'h0000_4180, for decode and next-PC use
  - FSM state typedef `ifu_state_t`, 2 bits: IDLE=0, REQ=1, WAIT=2, HOLD=3
- No sub-module: the FSM, PC register and instruction latch form one module.

## Test plan
- Reset release, `gnt`=1 immediate, `rvalid` next cycle with rdata=32'h2408_0005, ready=1, npc=32'h0000_3004 → `imem_addr`=32'h0000_3000; `instr_valid` in the 4th cycle with instr=32'h2408_0005, instr_pc=32'h0000_3000; next request at 32'h0000_3004.
- `gnt` withheld 3 cycles → `imem_req`=1 and `imem_addr` constant for 4 cycles; exactly one WAIT entry.
- HOLD with `ready`=0 for 5 cycles while npc toggles, then ready=1 with npc=32'h0000_4180 → instr stable throughout; pc becomes 32'h0000_4180.
- npc=32'h0000_3002 accepted → no `imem_req`; next cycle `instr_valid`=1, `instr_adel`=1, instr=0, instr_pc=32'h0000_3002.
- `rst_n`=0 during WAIT, then `rvalid`=1 with data 32'hDEAD_BEEF after reset release → pc=32'h0000_3000, instr=0; the DEAD_BEEF response never appears on `instr`.
- Spurious `imem_rvalid`=1 in REQ and HOLD → no change to `instr` or state.
